// File: rtl/id_scanner.sv
// ---------------------------------------------------------------------------
// id_scanner
// Streaming identifier tokenizer. One character is consumed per cycle with
// char_valid=1. Letter-led runs of letters/digits form tokens; a separator
// closes the token and reports its length, whether it ended in a digit, and
// bumps a running token counter. The legacy `match` flag (digit inside a
// letter-led token) is preserved.
//
// Parameters
//   CHAR_W    character width (ASCII classes)
//   MAX_LEN   maximum token length, 0 = unlimited (length saturates)
//   LEN_W     width of the length counter / tok_len
//   CNT_W     width of tok_cnt
//   ALLOW_US  1: '_' counts as a letter
//   STRICT    1: runs starting with a digit are discarded up to a separator
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   char           input character
//   char_valid     char is consumed this cycle
//   clr_cnt        synchronous clear of tok_cnt
//   match          digit accepted inside a letter-led token
//   tok_done       one-cycle pulse, a token ended on a separator
//   tok_len        length of the last completed token (held)
//   tok_digit_end  last completed token ended in a digit (held)
//   ovf            one-cycle pulse, token exceeded MAX_LEN
//   tok_cnt        number of tok_done pulses, wrapping
// ---------------------------------------------------------------------------
module id_scanner #(
    parameter int CHAR_W   = 8,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int CNT_W    = 16,
    parameter int ALLOW_US = 0,
    parameter int STRICT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAR_W-1:0] char,
    input  logic              char_valid,
    input  logic              clr_cnt,
    output logic              match,
    output logic              tok_done,
    output logic [LEN_W-1:0]  tok_len,
    output logic              tok_digit_end,
    output logic              ovf,
    output logic [CNT_W-1:0]  tok_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALPHA = 3'd1,
        ST_DIGIT = 3'd2,
        ST_SKIP  = 3'd3,
        ST_OVF   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_nxt_s;
    logic [LEN_W-1:0]   len_inc_s;
    logic               limit_hit_s;
    logic               match_r;
    logic               match_nxt_s;
    logic               done_r;
    logic               done_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic [LEN_W-1:0]   tok_len_r;
    logic [LEN_W-1:0]   tok_len_nxt_s;
    logic               tde_r;
    logic               tde_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               is_letter_s;
    logic               is_digit_s;
    logic               is_us_s;
    logic               is_l_s;
    logic               is_sep_s;

    // Character classification into letter (L), digit (D) and separator (S).
    always_comb begin
        is_letter_s = ((char >= CHAR_W'(65)) && (char <= CHAR_W'(90))) ||
                      ((char >= CHAR_W'(97)) && (char <= CHAR_W'(122)));
        is_digit_s  = (char >= CHAR_W'(48)) && (char <= CHAR_W'(57));
        is_us_s     = (ALLOW_US != 0) && (char == CHAR_W'(95));
        is_l_s      = is_letter_s || is_us_s;
        is_sep_s    = !(is_l_s || is_digit_s);
    end

    // Length helpers: saturating increment (only matters when MAX_LEN=0)
    // and the overflow limit test.
    always_comb begin
        if (len_r == {LEN_W{1'b1}}) begin
            len_inc_s = len_r;
        end else begin
            len_inc_s = len_r + LEN_W'(1);
        end
        limit_hit_s = (MAX_LEN != 0) && (len_r == LEN_W'(MAX_LEN));
    end

    // Next-state and next-output logic of the token FSM.
    always_comb begin
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        match_nxt_s   = 1'b0;
        done_nxt_s    = 1'b0;
        ovf_nxt_s     = 1'b0;
        tok_len_nxt_s = tok_len_r;
        tde_nxt_s     = tde_r;
        if (char_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_l_s) begin
                        state_nxt_s = ST_ALPHA;
                        len_nxt_s   = LEN_W'(1);
                    end else if (is_digit_s) begin
                        state_nxt_s = (STRICT != 0) ? ST_SKIP : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ALPHA, ST_DIGIT: begin
                    // Limit test comes first: an over-long token never matches.
                    if (!is_sep_s && limit_hit_s) begin
                        state_nxt_s = ST_OVF;
                        ovf_nxt_s   = 1'b1;
                    end else if (is_l_s) begin
                        state_nxt_s = ST_ALPHA;
                        len_nxt_s   = len_inc_s;
                    end else if (is_digit_s) begin
                        state_nxt_s = ST_DIGIT;
                        len_nxt_s   = len_inc_s;
                        match_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                        done_nxt_s    = 1'b1;
                        tok_len_nxt_s = len_r;
                        tde_nxt_s     = (state_r == ST_DIGIT);
                    end
                end
                ST_SKIP, ST_OVF: begin
                    if (is_sep_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Token counter: clear wins over hold, but a coincident token still counts.
    always_comb begin
        if (clr_cnt) begin
            cnt_nxt_s = done_nxt_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (done_nxt_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            len_r     <= {LEN_W{1'b0}};
            match_r   <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            tok_len_r <= {LEN_W{1'b0}};
            tde_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            len_r     <= len_nxt_s;
            match_r   <= match_nxt_s;
            done_r    <= done_nxt_s;
            ovf_r     <= ovf_nxt_s;
            tok_len_r <= tok_len_nxt_s;
            tde_r     <= tde_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign match         = match_r;
    assign tok_done      = done_r;
    assign tok_len       = tok_len_r;
    assign tok_digit_end = tde_r;
    assign ovf           = ovf_r;
    assign tok_cnt       = cnt_r;

endmodule

// File: tb/tb_id_scanner.sv
// ---------------------------------------------------------------------------
// tb_id_scanner
// Five id_scanner instances with different configurations share one input
// stream:
//   0: STRICT=0 MAX_LEN=16 ALLOW_US=0   1: STRICT=1 MAX_LEN=16 ALLOW_US=0
//   2: STRICT=0 MAX_LEN=4  ALLOW_US=0   3: STRICT=0 MAX_LEN=16 ALLOW_US=1
//   4: STRICT=0 MAX_LEN=0  ALLOW_US=0
// Directed scenarios compare against hand-derived constants; the random
// scenario compares against a token-level model of the character rules.
// ---------------------------------------------------------------------------
module tb_id_scanner;

    localparam int NI = 5;
    localparam int C_STRICT [NI] = '{0, 1, 0, 0, 0};
    localparam int C_MAX    [NI] = '{16, 16, 4, 16, 0};
    localparam int C_US     [NI] = '{0, 0, 0, 1, 0};

    logic       clk;
    logic       rst_n;
    logic [7:0] char_s;
    logic       char_valid_s;
    logic       clr_cnt_s;

    logic        match_w [NI];
    logic        done_w  [NI];
    logic [4:0]  len_w   [NI];
    logic        tde_w   [NI];
    logic        ovf_w   [NI];
    logic [15:0] cnt_w   [NI];

    int n_pass;
    int n_total;

    // Model: mode 0 = between tokens, 1 = inside token, 2 = discarding run.
    int          m_mode [NI];
    int          m_len  [NI];
    bit          m_lastd[NI];
    bit          e_match[NI];
    bit          e_done [NI];
    int          e_len  [NI];
    bit          e_tde  [NI];
    bit          e_ovf  [NI];
    int          e_cnt  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        id_scanner #(
            .CHAR_W  (8),
            .MAX_LEN (C_MAX[g]),
            .LEN_W   (5),
            .CNT_W   (16),
            .ALLOW_US(C_US[g]),
            .STRICT  (C_STRICT[g])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .char         (char_s),
            .char_valid   (char_valid_s),
            .clr_cnt      (clr_cnt_s),
            .match        (match_w[g]),
            .tok_done     (done_w[g]),
            .tok_len      (len_w[g]),
            .tok_digit_end(tde_w[g]),
            .ovf          (ovf_w[g]),
            .tok_cnt      (cnt_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cls_of(input logic [7:0] c, input int us);
        if ((c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122) ||
            (us != 0 && c == 8'd95)) return 1;
        if (c >= 8'd48 && c <= 8'd57) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_mode[k] = 0; m_len[k] = 0; m_lastd[k] = 1'b0;
            e_match[k] = 1'b0; e_done[k] = 1'b0; e_len[k] = 0;
            e_tde[k] = 1'b0; e_ovf[k] = 1'b0; e_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] c, input logic v, input logic clr);
        int cl;
        for (int k = 0; k < NI; k++) begin
            e_match[k] = 1'b0; e_done[k] = 1'b0; e_ovf[k] = 1'b0;
            if (v) begin
                cl = cls_of(c, C_US[k]);
                if (m_mode[k] == 0) begin
                    if (cl == 1) begin
                        m_mode[k] = 1; m_len[k] = 1; m_lastd[k] = 1'b0;
                    end else if (cl == 2 && C_STRICT[k] != 0) begin
                        m_mode[k] = 2;
                    end
                end else if (m_mode[k] == 1) begin
                    if (cl != 0 && C_MAX[k] > 0 && m_len[k] == C_MAX[k]) begin
                        m_mode[k] = 2; e_ovf[k] = 1'b1;
                    end else if (cl != 0) begin
                        m_len[k] = (m_len[k] + 1 > 31) ? 31 : m_len[k] + 1;
                        m_lastd[k] = (cl == 2);
                        e_match[k] = (cl == 2);
                    end else begin
                        e_done[k] = 1'b1; e_len[k] = m_len[k];
                        e_tde[k] = m_lastd[k]; m_mode[k] = 0;
                    end
                end else if (cl == 0) begin
                    m_mode[k] = 0;
                end
            end
            if (clr) e_cnt[k] = e_done[k] ? 1 : 0;
            else if (e_done[k]) e_cnt[k] = (e_cnt[k] + 1) % 65536;
        end
    endtask

    // One clock: apply inputs, advance the model with the edge, sample 1 ns later.
    task automatic drive(input logic [7:0] c, input logic v, input logic clr);
        char_s = c; char_valid_s = v; clr_cnt_s = clr;
        @(posedge clk);
        model_step(c, v, clr);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; char_s = 8'd0; char_valid_s = 1'b0; clr_cnt_s = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if ({match_w[k], done_w[k], len_w[k], tde_w[k], ovf_w[k], cnt_w[k]} !== 26'd0)
                $display("FAIL reset inst%0d: got m%0b d%0b l%0d t%0b o%0b c%0d want all 0",
                         k, match_w[k], done_w[k], len_w[k], tde_w[k], ovf_w[k], cnt_w[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        string s  = "ab12 ";
        string em = "00110";
        string ed = "00001";
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, 1'b0);
            n_total++;
            if (match_w[0] !== (em[i] == 8'h31) || done_w[0] !== (ed[i] == 8'h31))
                $display("FAIL basic char%0d: got match=%0b done=%0b want %s/%s",
                         i, match_w[0], done_w[0], em.substr(i, i), ed.substr(i, i));
            else n_pass++;
        end
        n_total++;
        if (len_w[0] !== 5'd4 || tde_w[0] !== 1'b1 || cnt_w[0] !== 16'd1)
            $display("FAIL basic_tok: got len=%0d tde=%0b cnt=%0d want 4 1 1",
                     len_w[0], tde_w[0], cnt_w[0]);
        else n_pass++;
    endtask

    task automatic test_legacy_strict();
        string s  = "12ab3;";
        string em = "000010";
        string ed = "000001";
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, 1'b0);
            n_total++;
            if (match_w[0] !== (em[i] == 8'h31) || done_w[0] !== (ed[i] == 8'h31))
                $display("FAIL legacy char%0d: got match=%0b done=%0b want %s/%s",
                         i, match_w[0], done_w[0], em.substr(i, i), ed.substr(i, i));
            else n_pass++;
            n_total++;
            if (match_w[1] !== 1'b0 || done_w[1] !== 1'b0)
                $display("FAIL strict char%0d: got match=%0b done=%0b want 0/0",
                         i, match_w[1], done_w[1]);
            else n_pass++;
        end
        n_total++;
        if (len_w[0] !== 5'd3 || tde_w[0] !== 1'b1 || cnt_w[0] !== 16'd2 || cnt_w[1] !== 16'd1)
            $display("FAIL legacy_tok: got len=%0d tde=%0b cnt0=%0d cnt1=%0d want 3 1 2 1",
                     len_w[0], tde_w[0], cnt_w[0], cnt_w[1]);
        else n_pass++;
    endtask

    task automatic test_ovf();
        string s  = "abcde1 x ";
        string eo = "000010000";
        string ed = "000000001";
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, 1'b0);
            n_total++;
            if (ovf_w[2] !== (eo[i] == 8'h31) || done_w[2] !== (ed[i] == 8'h31) ||
                match_w[2] !== 1'b0)
                $display("FAIL ovf char%0d: got ovf=%0b done=%0b match=%0b want %s/%s/0",
                         i, ovf_w[2], done_w[2], match_w[2], eo.substr(i, i), ed.substr(i, i));
            else n_pass++;
        end
        n_total++;
        if (len_w[2] !== 5'd1 || tde_w[2] !== 1'b0)
            $display("FAIL ovf_tok: got len=%0d tde=%0b want 1 0", len_w[2], tde_w[2]);
        else n_pass++;
    endtask

    task automatic test_underscore();
        string s = "_a9 ";
        for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
        n_total++;
        if (done_w[3] !== 1'b1 || len_w[3] !== 5'd3 || tde_w[3] !== 1'b1)
            $display("FAIL us_on: got done=%0b len=%0d tde=%0b want 1 3 1",
                     done_w[3], len_w[3], tde_w[3]);
        else n_pass++;
        n_total++;
        if (done_w[0] !== 1'b1 || len_w[0] !== 5'd2)
            $display("FAIL us_off: got done=%0b len=%0d want 1 2", done_w[0], len_w[0]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] cs [6] = '{8'h61, 8'h31, 8'h39, 8'h31, 8'h5a, 8'h20};
        bit         vs [6] = '{1, 0, 0, 1, 0, 1};
        bit         ems[6] = '{0, 0, 0, 1, 0, 0};
        bit         eds[6] = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            drive(vs[i] ? cs[i] : 8'($urandom_range(0, 255)), vs[i], 1'b0);
            n_total++;
            if (match_w[0] !== ems[i] || done_w[0] !== eds[i])
                $display("FAIL stall step%0d: got match=%0b done=%0b want %0b/%0b",
                         i, match_w[0], done_w[0], ems[i], eds[i]);
            else n_pass++;
        end
        n_total++;
        if (len_w[0] !== 5'd2 || tde_w[0] !== 1'b1)
            $display("FAIL stall_tok: got len=%0d tde=%0b want 2 1", len_w[0], tde_w[0]);
        else n_pass++;
    endtask

    task automatic test_clr();
        drive(8'h20, 1'b0, 1'b1);
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if (cnt_w[k] !== 16'd0)
                $display("FAIL clr_alone inst%0d: got %0d want 0", k, cnt_w[k]);
            else n_pass++;
        end
        drive(8'h61, 1'b1, 1'b0);
        drive(8'h20, 1'b1, 1'b1);
        n_total++;
        if (done_w[0] !== 1'b1 || cnt_w[0] !== 16'd1)
            $display("FAIL clr_with_done: got done=%0b cnt=%0d want 1 1", done_w[0], cnt_w[0]);
        else n_pass++;
        drive(8'h20, 1'b1, 1'b0);
        n_total++;
        if (done_w[0] !== 1'b0 || cnt_w[0] !== 16'd1)
            $display("FAIL sep_sep: got done=%0b cnt=%0d want 0 1", done_w[0], cnt_w[0]);
        else n_pass++;
    endtask

    task automatic test_len_limits();
        for (int i = 0; i < 40; i++) begin
            drive(8'h7a, 1'b1, 1'b0);
            n_total++;
            if (ovf_w[0] !== (i == 16) || ovf_w[4] !== 1'b0)
                $display("FAIL limit char%0d: got ovf16=%0b ovf0=%0b want %0b/0",
                         i, ovf_w[0], ovf_w[4], (i == 16));
            else n_pass++;
        end
        drive(8'h20, 1'b1, 1'b0);
        n_total++;
        if (done_w[4] !== 1'b1 || len_w[4] !== 5'd31 || done_w[0] !== 1'b0)
            $display("FAIL saturate: got done0=%0b len=%0d done16=%0b want 1 31 0",
                     done_w[4], len_w[4], done_w[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(8'h61, 1'b1, 1'b0);
        drive(8'h62, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            n_total++;
            if ({match_w[k], done_w[k], len_w[k], tde_w[k], ovf_w[k], cnt_w[k]} !== 26'd0)
                $display("FAIL async_reset inst%0d: got l%0d c%0d t%0b want all 0",
                         k, len_w[k], cnt_w[k], tde_w[k]);
            else n_pass++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(8'h63, 1'b1, 1'b0);
        drive(8'h20, 1'b1, 1'b0);
        n_total++;
        if (done_w[0] !== 1'b1 || len_w[0] !== 5'd1 || cnt_w[0] !== 16'd1)
            $display("FAIL after_reset: got done=%0b len=%0d cnt=%0d want 1 1 1",
                     done_w[0], len_w[0], cnt_w[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] c;
        int         r;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    c = 8'(97 + $urandom_range(0, 25));
                2, 3:    c = 8'(65 + $urandom_range(0, 25));
                4, 5:    c = 8'(48 + $urandom_range(0, 9));
                6:       c = 8'd95;
                7:       c = 8'd32;
                8:       c = 8'd59;
                default: c = 8'($urandom_range(0, 255));
            endcase
            drive(c, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
            for (int k = 0; k < NI; k++) begin
                n_total++;
                if (match_w[k] !== e_match[k] || done_w[k] !== e_done[k] ||
                    ovf_w[k] !== e_ovf[k] || len_w[k] !== 5'(e_len[k]) ||
                    tde_w[k] !== e_tde[k] || cnt_w[k] !== 16'(e_cnt[k]))
                    $display("FAIL random cyc%0d inst%0d: got m%0b d%0b o%0b l%0d t%0b c%0d want m%0b d%0b o%0b l%0d t%0b c%0d",
                             n, k, match_w[k], done_w[k], ovf_w[k], len_w[k], tde_w[k], cnt_w[k],
                             e_match[k], e_done[k], e_ovf[k], e_len[k], e_tde[k], e_cnt[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_legacy_strict();
        test_ovf();
        test_underscore();
        test_stall();
        test_clr();
        test_len_limits();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
